// File: rtl/bcd_preset_entry_pkg.sv
// Shared definitions for the BCD preset entry block: FSM encoding and BCD digit limits.
// The state width matches the counter FSM so both can be probed with the same decode.
package bcd_preset_entry_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EDIT_LO = 3'd1,
      ST_EDIT_HI = 3'd2,
      ST_LOAD    = 3'd3
   } entry_state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

endpackage

// File: rtl/bcd_preset_entry_digit_updn.sv
// One BCD digit register with mod-10 step up/down and no carry or borrow out.
// Asserting inc and dec together leaves the digit unchanged.
module bcd_digit_updn
   import bcd_preset_entry_pkg::*;
(
   input  logic       clk_fsm,
   input  logic       reset_d,
   input  logic       en,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] digit
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   always_comb begin
      digit_d = digit_q;
      if (en && inc && !dec) begin
         digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else if (en && dec && !inc) begin
         digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
   end

   always_ff @(posedge clk_fsm or posedge reset_d) begin
      if (reset_d) begin
         digit_q <= BCD_MIN;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;

endmodule

// File: rtl/bcd_preset_entry.sv
// Operator preset entry for the two-digit BCD counter: button pulses edit a 00-99 preset,
// which is then offered to the counter over load_req/load_ack; also drives edit-digit blinking.
module bcd_preset_entry
   import bcd_preset_entry_pkg::*;
#(
   parameter int BLINK_HALF = 4
) (
   input  logic       clk_fsm,
   input  logic       reset_d,
   input  logic       edit_1pulse,
   input  logic       sel_1pulse,
   input  logic       inc_1pulse,
   input  logic       dec_1pulse,
   input  logic       counter_idle,
   input  logic       load_ack,
   output logic [3:0] preset_lo,
   output logic [3:0] preset_hi,
   output logic       load_req,
   output logic       editing,
   output logic       edit_digit,
   output logic       blank_lo,
   output logic       blank_hi
);

   localparam int BLINK_W = $clog2(2 * BLINK_HALF);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
   localparam logic [BLINK_W-1:0] BLINK_OFF  = BLINK_W'(BLINK_HALF);

   entry_state_e       state_q;
   entry_state_e       state_d;
   logic [BLINK_W-1:0] blink_q;
   logic [BLINK_W-1:0] blink_d;
   logic               blink_clr;
   logic               step_en;
   logic               en_lo;
   logic               en_hi;
   logic               in_edit;

   assign in_edit = (state_q == ST_EDIT_LO) || (state_q == ST_EDIT_HI);

   // Abort on counter_idle low outranks every pulse; among pulses edit > sel > inc/dec.
   always_comb begin
      state_d   = state_q;
      blink_clr = 1'b0;
      step_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (edit_1pulse && counter_idle) begin
               state_d   = ST_EDIT_LO;
               blink_clr = 1'b1;
            end
         end
         ST_EDIT_LO, ST_EDIT_HI: begin
            if (!counter_idle) begin
               state_d = ST_IDLE;
            end else if (edit_1pulse) begin
               state_d = ST_LOAD;
            end else if (sel_1pulse) begin
               state_d   = (state_q == ST_EDIT_LO) ? ST_EDIT_HI : ST_EDIT_LO;
               blink_clr = 1'b1;
            end else if (inc_1pulse != dec_1pulse) begin
               step_en   = 1'b1;
               blink_clr = 1'b1;
            end
         end
         ST_LOAD: begin
            if (load_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign en_lo = step_en && (state_q == ST_EDIT_LO);
   assign en_hi = step_en && (state_q == ST_EDIT_HI);

   always_comb begin
      blink_d = '0;
      if (blink_clr) begin
         blink_d = '0;
      end else if (in_edit) begin
         blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
      end
   end

   always_ff @(posedge clk_fsm or posedge reset_d) begin
      if (reset_d) begin
         state_q <= ST_IDLE;
         blink_q <= '0;
      end else begin
         state_q <= state_d;
         blink_q <= blink_d;
      end
   end

   bcd_digit_updn u_digit_lo (
      .clk_fsm (clk_fsm),
      .reset_d (reset_d),
      .en      (en_lo),
      .inc     (inc_1pulse),
      .dec     (dec_1pulse),
      .digit   (preset_lo)
   );

   bcd_digit_updn u_digit_hi (
      .clk_fsm (clk_fsm),
      .reset_d (reset_d),
      .en      (en_hi),
      .inc     (inc_1pulse),
      .dec     (dec_1pulse),
      .digit   (preset_hi)
   );

   // Decoding straight from state_q lets the asynchronous reset drop load_req at once.
   assign load_req   = (state_q == ST_LOAD);
   assign editing    = in_edit;
   assign edit_digit = (state_q == ST_EDIT_HI);
   assign blank_lo   = (state_q == ST_EDIT_LO) && (blink_q >= BLINK_OFF);
   assign blank_hi   = (state_q == ST_EDIT_HI) && (blink_q >= BLINK_OFF);

endmodule

// File: tb/tb_bcd_preset_entry.sv
// Bench for bcd_preset_entry: directed scenarios then random pulses, checked every cycle
// against a behavioural model of the preset/edit/load/blink rules.
module tb_bcd_preset_entry;

   localparam int BH = 2;

   logic       clk_fsm = 1'b0;
   logic       reset_d = 1'b0;
   logic       edit_1pulse = 1'b0;
   logic       sel_1pulse = 1'b0;
   logic       inc_1pulse = 1'b0;
   logic       dec_1pulse = 1'b0;
   logic       counter_idle = 1'b1;
   logic       load_ack = 1'b0;
   logic [3:0] preset_lo;
   logic [3:0] preset_hi;
   logic       load_req;
   logic       editing;
   logic       edit_digit;
   logic       blank_lo;
   logic       blank_hi;

   int vectors = 0;
   int miscompares = 0;

   // Model: mode 0 = idle, 1 = editing, 2 = waiting for ack.
   int m_mode;
   int m_dig;
   int m_pre [2];
   int m_cnt;

   bcd_preset_entry #(.BLINK_HALF(BH)) dut (
      .clk_fsm      (clk_fsm),
      .reset_d      (reset_d),
      .edit_1pulse  (edit_1pulse),
      .sel_1pulse   (sel_1pulse),
      .inc_1pulse   (inc_1pulse),
      .dec_1pulse   (dec_1pulse),
      .counter_idle (counter_idle),
      .load_ack     (load_ack),
      .preset_lo    (preset_lo),
      .preset_hi    (preset_hi),
      .load_req     (load_req),
      .editing      (editing),
      .edit_digit   (edit_digit),
      .blank_lo     (blank_lo),
      .blank_hi     (blank_hi)
   );

   always #5 clk_fsm = ~clk_fsm;

   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("preset_lo", int'(preset_lo), m_pre[0]);
      chk("preset_hi", int'(preset_hi), m_pre[1]);
      chk("load_req", int'(load_req), (m_mode == 2) ? 1 : 0);
      chk("editing", int'(editing), (m_mode == 1) ? 1 : 0);
      if (m_mode == 1) chk("edit_digit", int'(edit_digit), m_dig);
      chk("blank_lo", int'(blank_lo), (m_mode == 1 && m_dig == 0 && m_cnt >= BH) ? 1 : 0);
      chk("blank_hi", int'(blank_hi), (m_mode == 1 && m_dig == 1 && m_cnt >= BH) ? 1 : 0);
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_dig = 0;
      m_pre[0] = 0;
      m_pre[1] = 0;
      m_cnt = 0;
   endtask

   task automatic model_step(input bit e, input bit s, input bit i, input bit d,
                             input bit ci, input bit ack);
      case (m_mode)
         0: if (e && ci) begin
            m_mode = 1;
            m_dig = 0;
            m_cnt = 0;
         end
         1: begin
            if (!ci) m_mode = 0;
            else if (e) m_mode = 2;
            else if (s) begin
               m_dig = 1 - m_dig;
               m_cnt = 0;
            end else if (i != d) begin
               m_pre[m_dig] = i ? (m_pre[m_dig] + 1) % 10 : (m_pre[m_dig] + 9) % 10;
               m_cnt = 0;
            end else m_cnt = (m_cnt + 1) % (2 * BH);
         end
         default: if (ack) m_mode = 0;
      endcase
   endtask

   // Drive one cycle of inputs, clock it, update the model and check 1 time unit later.
   task automatic cyc(input bit e, input bit s, input bit i, input bit d,
                      input bit ci, input bit ack);
      edit_1pulse = e;
      sel_1pulse = s;
      inc_1pulse = i;
      dec_1pulse = d;
      counter_idle = ci;
      load_ack = ack;
      @(posedge clk_fsm);
      model_step(e, s, i, d, ci, ack);
      #1;
      check_all();
   endtask

   task automatic idle_cyc(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      model_reset();
      #2 reset_d = 1'b1;
      #1;
      check_all();
      @(posedge clk_fsm);
      #1 reset_d = 1'b0;
      check_all();

      // Enter edit, units +3, tens -1, then load with a stalled ack.
      cyc(1, 0, 0, 0, 1, 0);
      repeat (3) cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);
      cyc(1, 0, 0, 0, 1, 0);
      chk("load_hi9", int'(preset_hi), 9);
      chk("load_lo3", int'(preset_lo), 3);
      cyc(0, 1, 1, 0, 0, 0);
      cyc(1, 0, 0, 1, 1, 0);
      repeat (3) cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 1);
      chk("ack_idle", int'(load_req), 0);

      // Wraps on both digits (units 3 -> 9 -> 0 -> 9, tens 9 -> 0 -> 9).
      cyc(1, 0, 0, 0, 1, 0);
      repeat (6) cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);

      // Simultaneous pulses.
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 1, 1, 0, 1, 0);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 0, 1, 1, 1, 0);
      cyc(1, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 1);

      // Guard and abort.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
      idle_cyc(2);

      // Blink pattern, then an inc at count 3 restarts it.
      cyc(1, 0, 0, 0, 1, 0);
      idle_cyc(3);
      cyc(0, 0, 1, 0, 1, 0);
      idle_cyc(5);
      cyc(0, 0, 0, 0, 0, 0);

      // Random pulses with occasional idle drop and random ack.
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 15) != 0), ($urandom_range(0, 2) == 0));
      end

      // Asynchronous reset while a load is pending.
      idle_cyc(1);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(1, 0, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);
      cyc(1, 0, 0, 0, 1, 0);
      chk("pre_reset_load", int'(load_req), 1);
      #2 reset_d = 1'b1;
      model_reset();
      #1;
      chk("async_load_req", int'(load_req), 0);
      chk("async_lo", int'(preset_lo), 0);
      chk("async_hi", int'(preset_hi), 0);
      @(posedge clk_fsm);
      #1 reset_d = 1'b0;
      cyc(0, 0, 0, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bcd_preset_entry.md
# bcd_preset_entry

Operator-side writer for the two-digit BCD up/down counter: turns single-cycle button pulses into a two-digit BCD preset (00–99) and hands it to the counter over a load_req/load_ack handshake. Sits between the onepulse conditioners and the counter's load port, in the clk_fsm domain. Also drives per-digit blink-blanking so the 7-segment scanner can show which digit is being edited.

## Interface
- BLINK_HALF, default 4: clk_fsm cycles per half blink period of the edited digit; legal range ≥1.
- clk_fsm  in  1  FSM clock; all state updates on rising edge.
- reset_d  in  1  reset, asynchronous, active-high.
- edit_1pulse  in  1  one-cycle pulse: enter edit / commit load.
- sel_1pulse  in  1  one-cycle pulse: toggle the edited digit.
- inc_1pulse  in  1  one-cycle pulse: increment the edited digit.
- dec_1pulse  in  1  one-cycle pulse: decrement the edited digit.
- counter_idle  in  1  counter is in INIT or paused; edit is permitted only while high.
- load_ack  in  1  counter has captured the preset; level, sampled on clk_fsm.
- preset_lo  out  4  preset units digit, BCD 0–9.
- preset_hi  out  4  preset tens digit, BCD 0–9.
- load_req  out  1  preset valid, counter must load it.
- editing  out  1  high in EDIT_LO/EDIT_HI.
- edit_digit  out  1  0 = units digit, 1 = tens digit; valid while editing.
- blank_lo  out  1  blank the units display digit this cycle.
- blank_hi  out  1  blank the tens display digit this cycle.

## Operation
- States: IDLE, EDIT_LO, EDIT_HI, LOAD. Any illegal encoding goes to IDLE on the next edge.
- IDLE: if edit_1pulse=1 and counter_idle=1, go to EDIT_LO. An edit pulse while counter_idle=0 is ignored. All other pulses are ignored.
- EDIT_LO/EDIT_HI, pulse priority per cycle is edit > sel > inc/dec; lower-priority pulses in the same cycle are discarded.
  - edit: go to LOAD.
  - sel: toggle between EDIT_LO and EDIT_HI; the preset is unchanged.
  - inc: the edited digit steps +1 mod 10 (9→0). There is no carry into the other digit.
  - dec: the edited digit steps −1 mod 10 (0→9). There is no borrow.
  - inc and dec together: no change.
  - counter_idle=0 while in EDIT_*: abort to IDLE with no load. The preset is retained.
- LOAD: load_req=1. preset_lo/preset_hi are frozen. All pulses and counter_idle are ignored. load_ack=1 → go to IDLE.
- The preset is never cleared except by reset. The next edit session starts from the last preset.
- Blink, active only in EDIT_*:
  - A counter counts 0..2·BLINK_HALF−1. It is reset to 0 on entry to EDIT_*, on sel, and on any applied inc/dec.
  - The active digit's blank is 0 for counts 0..BLINK_HALF−1 and 1 for the remainder.
  - The inactive digit's blank is always 0.
  - In IDLE and LOAD, blank_lo = blank_hi = 0.
- Outputs: load_req, editing and edit_digit are decoded from the registered state. preset_* are registers. blank_* are combinational from state and the blink count.
- Reset: IDLE, preset_lo=0, preset_hi=0, load_req=0, editing=0, edit_digit=0, blank_lo=0, blank_hi=0, blink count=0. Reset in any state, including LOAD mid-handshake, drops load_req immediately (asynchronous).

## Timing
- All latencies below are measured from the rising edge that samples the input, with outputs changing at that edge.
- Pulse→digit update: one edge. A pulse sampled at edge N gives the new preset value after edge N.
- edit in EDIT_* → load_req=1 after the same edge. The preset is stable from that edge until load_req falls.
- load_ack sampled high at edge M → load_req=0 after edge M.
  - If load_ack is already high when LOAD is entered, LOAD lasts exactly one cycle.
  - The minimum load_req width is one cycle.
- Abort on counter_idle=0 takes effect at the next edge.
- Pulse inputs are assumed exactly one clk_fsm cycle wide. A held input acts as a repeat on every cycle.

## Structure
- Shared package holds: state encoding constants (3-bit, matching the counter FSM width), BCD_MAX=9, BCD_MIN=0.
- Sub-module bcd_digit_updn: one 4-bit mod-10 register with en/inc/dec inputs and asynchronous reset to 0. It is instantiated twice (lo, hi), with en driven from the state.
- Top holds the FSM, the blink counter ($clog2(2·BLINK_HALF) bits) and the output decode.

## Test plan
- Reset, then edit (counter_idle=1), then inc ×3, sel, dec ×1, edit → load_req=1 with preset_hi=9, preset_lo=3. Hold load_ack=0 for 5 cycles: load_req stays 1 and the preset is frozen. Then load_ack=1 → IDLE next edge.
- Wrap, units digit: preset_lo=9, inc → 0 with preset_hi unchanged. Then dec → 9. Repeat on the tens digit.
- Simultaneous pulses in EDIT_LO:
  - sel+inc → EDIT_HI, no increment.
  - inc+dec → no change.
  - edit+sel → LOAD.
- Guard and abort:
  - edit with counter_idle=0 → stays IDLE.
  - In EDIT_HI, drop counter_idle → IDLE next edge, load_req never asserted, preset retained.
- Blink with BLINK_HALF=2 in EDIT_LO: blank_lo follows 0,0,1,1,0,… and blank_hi=0 throughout. An inc at count 3 restarts the pattern at 0.
- Assert reset_d asynchronously mid-LOAD → load_req=0 and preset=00 without waiting for a clock edge.
